canvas_painter: RTL
===================

# canvas_painter

Sequential brush engine that owns the 28x28 digit canvas feeding the display colour mapper and the NN input path. On each frame tick while the mouse button is held, it converts the cursor's screen position to a canvas cell. It then stamps a saturating intensity brush onto that cell and its neighbours, one cell write per clock. A clear request sweeps every cell to zero.

## Interface
- CENTER_INC, 16'h0400, increment added to the cursor cell
- NEIGH_INC, 16'h0200, increment added to each 4-connected neighbour
- DIAG_INC, 16'h0100, increment added to each diagonal neighbour (PAINTER_DIAG_EN only)
- X_ORG, 200, screen X of canvas left edge
- Y_ORG, 44, screen Y of canvas top edge
- Clk  in  1  system clock; the only clock
- Reset_n  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle strobe, once per video frame
- draw  in  1  mouse button level; paint while high
- clear  in  1  clear request level
- BallX, BallY  in  10 each  cursor screen coordinates
- canvas  out  16 x [27:0][27:0]  registered cell intensities, indexed canvas[x][y]
- busy  out  1  high while a stamp or clear is in progress

## Operation
- Cell map: offX = BallX - X_ORG and offY = BallY - Y_ORG, unsigned 10-bit. The cursor is inside the canvas iff BallX >= X_ORG, offX < 392, BallY >= Y_ORG and offY < 392.
- Cell coordinates are cx = offX/14 and cy = offY/14, each 0..27, computed combinationally by comparison and never by a divider.
- States: IDLE, C, N, S, W, E, CLR; with PAINTER_DIAG_EN also NE, NW, SE, SW.
- IDLE + clear=1: go to CLR with counter i = 0. clear has priority over frame_tick.
- IDLE + frame_tick + draw + inside: latch cx and cy, then go to C.
- IDLE + frame_tick otherwise (no draw, or cursor outside): stay in IDLE.
- frame_tick and clear are sampled only in IDLE. Ticks arriving while busy are dropped, not queued.
- Stamp sequence: C writes (cx,cy) with CENTER_INC. N writes (cx,cy-1), S writes (cx,cy+1), W writes (cx-1,cy) and E writes (cx+1,cy), each with NEIGH_INC.
- Without the macro, E returns to IDLE. With it, E moves to NE, NW, SE, SW, each written with DIAG_INC, and SW returns to IDLE.
- Off-grid neighbours (index -1 or 28): the write is suppressed but the state still takes its cycle.
- Arithmetic: new = min(old + inc, 16'h07FF), computed 17 bits wide, so cell[10:3] tops out at 8'hFF. Bits [15:11] are always 0.
- CLR: one cell per cycle at x = i/28, y = i%28, written to 0, for i = 0..783. At i = 783 return to IDLE.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous assert): every canvas cell = 0, state = IDLE, busy = 0, counter = 0. Reset mid-stamp or mid-clear aborts immediately, and completed writes are also zeroed.
- Let edge k be the edge that samples frame_tick in IDLE.
- Stamp, non-diagonal build: centre is written at k+1, then N/S/W/E at k+2..k+5. busy is high after k through k+5, and the next tick is accepted at k+6.
- Stamp, diagonal build: diagonal cells are written at k+6..k+9, and the next tick is accepted at k+10.
- Clear: busy spans 784 cycles; cell i is zero after edge k+1+i.
- canvas is purely registered, with no combinational path from inputs.
- The cursor may move during a stamp; coordinates latched at edge k are used throughout.

## Configuration
- PAINTER_DIAG_EN defined: 9-cell brush using DIAG_INC, stamp takes 9 cycles.
- PAINTER_DIAG_EN undefined: 5-cell plus-shaped brush, stamp takes 5 cycles. Diagonal states and DIAG_INC are unused.

## Test plan
- Reset, then BallX=305 and BallY=149 (cell 7,7), draw=1, one tick -> canvas[7][7]=0x0400, and [7][6], [7][8], [6][7], [8][7] = 0x0200; all other cells 0. busy is high for 5 cycles.
- Same cursor, 3 ticks spaced 10 cycles apart -> centre saturates at 0x07FF (not 0x0C00) and neighbours = 0x0600.
- BallX=200, BallY=44 (cell 0,0), one tick -> [0][0]=0x0400, [0][1] and [1][0] = 0x0200, no wrap-around writes to row or column 27.
- BallX=199 or BallY=436 with a tick, or draw=0 with a tick -> canvas unchanged and busy stays 0.
- After painting, clear=1 in IDLE -> busy high for exactly 784 cycles, all cells 0. A frame_tick during CLR is ignored.
- Assert Reset_n=0 mid-clear (at i=400) -> all outputs immediately take their reset values, and the FSM is in IDLE after release. With PAINTER_DIAG_EN, a cell-(7,7) tick also gives diagonals = 0x0100.

Source files
------------

// File: rtl/canvas_painter.sv
// Brush engine for the 28x28 digit canvas: stamps a saturating brush per frame tick, sweeps on clear.
// Define PAINTER_DIAG_EN for the 9-cell brush (adds diagonal neighbours).
module canvas_painter (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_tick,
    input  logic                     draw,
    input  logic                     clear,
    input  logic [9:0]               BallX,
    input  logic [9:0]               BallY,
    output logic [27:0][27:0][15:0]  canvas,
    output logic                     busy
);

    localparam logic [15:0] CENTER_INC = 16'h0400;
    localparam logic [15:0] NEIGH_INC  = 16'h0200;
`ifdef PAINTER_DIAG_EN
    localparam logic [15:0] DIAG_INC   = 16'h0100;
`endif
    localparam logic [9:0]  X_ORG      = 10'd200;
    localparam logic [9:0]  Y_ORG      = 10'd44;
    localparam logic [9:0]  SPAN       = 10'd392;
    localparam logic [4:0]  LAST       = 5'd27;

    typedef enum logic [3:0] {
        StIdle, StC, StN, StS, StW, StE, StClr
`ifdef PAINTER_DIAG_EN
        , StNe, StNw, StSe, StSw
`endif
    } state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_cx, r_cy, r_clr_x, r_clr_y;
    logic [9:0]  w_offx, w_offy;
    logic [4:0]  w_cx, w_cy, w_wx, w_wy;
    logic        w_inside, w_latch, w_we, w_clr;
    logic [15:0] w_inc, w_old, w_new;
    logic [16:0] w_sum;

    assign w_offx   = BallX - X_ORG;
    assign w_offy   = BallY - Y_ORG;
    assign w_inside = (BallX >= X_ORG) && (w_offx < SPAN) && (BallY >= Y_ORG) && (w_offy < SPAN);

    // Cell index = number of 14-pixel boundaries at or below the offset.
    always_comb begin
        w_cx = '0;
        w_cy = '0;
        for (int k = 1; k < 28; k++) begin
            if (w_offx >= 10'(k * 14)) w_cx = 5'(k);
            if (w_offy >= 10'(k * 14)) w_cy = 5'(k);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_we         = 1'b0;
        w_clr        = 1'b0;
        w_wx         = r_cx;
        w_wy         = r_cy;
        w_inc        = NEIGH_INC;
        unique case (r_state)
            StIdle: begin
                if (clear) begin
                    w_state_next = StClr;
                end else if (frame_tick && draw && w_inside) begin
                    w_latch      = 1'b1;
                    w_state_next = StC;
                end
            end
            StC: begin
                w_we         = 1'b1;
                w_inc        = CENTER_INC;
                w_state_next = StN;
            end
            StN: begin
                w_we         = (r_cy != 5'd0);
                w_wy         = r_cy - 5'd1;
                w_state_next = StS;
            end
            StS: begin
                w_we         = (r_cy != LAST);
                w_wy         = r_cy + 5'd1;
                w_state_next = StW;
            end
            StW: begin
                w_we         = (r_cx != 5'd0);
                w_wx         = r_cx - 5'd1;
                w_state_next = StE;
            end
            StE: begin
                w_we         = (r_cx != LAST);
                w_wx         = r_cx + 5'd1;
`ifdef PAINTER_DIAG_EN
                w_state_next = StNe;
`else
                w_state_next = StIdle;
`endif
            end
`ifdef PAINTER_DIAG_EN
            StNe: begin
                w_we         = (r_cx != LAST) && (r_cy != 5'd0);
                w_wx         = r_cx + 5'd1;
                w_wy         = r_cy - 5'd1;
                w_inc        = DIAG_INC;
                w_state_next = StNw;
            end
            StNw: begin
                w_we         = (r_cx != 5'd0) && (r_cy != 5'd0);
                w_wx         = r_cx - 5'd1;
                w_wy         = r_cy - 5'd1;
                w_inc        = DIAG_INC;
                w_state_next = StSe;
            end
            StSe: begin
                w_we         = (r_cx != LAST) && (r_cy != LAST);
                w_wx         = r_cx + 5'd1;
                w_wy         = r_cy + 5'd1;
                w_inc        = DIAG_INC;
                w_state_next = StSw;
            end
            StSw: begin
                w_we         = (r_cx != 5'd0) && (r_cy != LAST);
                w_wx         = r_cx - 5'd1;
                w_wy         = r_cy + 5'd1;
                w_inc        = DIAG_INC;
                w_state_next = StIdle;
            end
`endif
            StClr: begin
                w_clr = 1'b1;
                w_wx  = r_clr_x;
                w_wy  = r_clr_y;
                if (r_clr_x == LAST && r_clr_y == LAST) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Saturating add done 17 bits wide so the carry can never wrap.
    assign w_old = canvas[w_wx][w_wy];
    assign w_sum = {1'b0, w_old} + {1'b0, w_inc};
    assign w_new = (w_sum > 17'h007FF) ? 16'h07FF : w_sum[15:0];
    assign busy  = (r_state != StIdle);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cx    <= '0;
            r_cy    <= '0;
            r_clr_x <= '0;
            r_clr_y <= '0;
            canvas  <= '0;
        end else begin
            if (w_latch) begin
                r_cx <= w_cx;
                r_cy <= w_cy;
            end
            if (w_clr) begin
                canvas[w_wx][w_wy] <= '0;
                if (r_clr_y == LAST) begin
                    r_clr_y <= '0;
                    r_clr_x <= (r_clr_x == LAST) ? 5'd0 : r_clr_x + 5'd1;
                end else begin
                    r_clr_y <= r_clr_y + 5'd1;
                end
            end else if (w_we) begin
                canvas[w_wx][w_wy] <= w_new;
            end
        end
    end

endmodule
